// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl: coefficient bank controller and input sequencer for an NTAPS-tap FIR.
//
// Ports:
//   CLK, RST                      clock (rising edge), synchronous active-high reset
//   CFG_WE/CFG_ADDR/CFG_DATA      shadow coefficient write port
//   CFG_COMMIT/CFG_CLR            request shadow->active swap, optional zero flush
//   CFG_BUSY                      commit sequence in progress
//   SRC_VIN/SRC_DIN/SRC_RDY       upstream sample handshake
//   FIR_VIN/FIR_DIN               sample stream into the FIR
//   FIR_VOUT                      FIR result valid (one per accepted FIR_VIN)
//   H_BUS                         active coefficients, tap k at [k*WIDTH +: WIDTH]
//   SNK_VOUT                      FIR_VOUT with flush results masked off
//   ERR                           sticky in-flight counter under/overflow
module fir_coef_ctrl #(
  parameter int unsigned NTAPS = 11,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CFG_WE,
  input  logic [3:0]             CFG_ADDR,
  input  logic [WIDTH-1:0]       CFG_DATA,
  input  logic                   CFG_COMMIT,
  input  logic                   CFG_CLR,
  output logic                   CFG_BUSY,
  input  logic                   SRC_VIN,
  input  logic [WIDTH-1:0]       SRC_DIN,
  output logic                   SRC_RDY,
  output logic                   FIR_VIN,
  output logic [WIDTH-1:0]       FIR_DIN,
  input  logic                   FIR_VOUT,
  output logic [NTAPS*WIDTH-1:0] H_BUS,
  output logic                   SNK_VOUT,
  output logic                   ERR
);

  localparam int unsigned ZW = $clog2(NTAPS);
  localparam logic [3:0] LastAddr = 4'(NTAPS - 1);
  localparam logic [ZW-1:0] FlushLen = ZW'(NTAPS - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StRun, StDrain, StSwap, StZfill} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] shadow_q [NTAPS];
  logic [WIDTH-1:0] active_q [NTAPS];
  logic [CNT_W-1:0] inflight_q;
  logic [ZW-1:0]    discard_q;
  logic [ZW-1:0]    zcnt_q;
  logic             err_q;
  logic             clr_flag_q;
  logic             flush_start;

  // Zero flush begins on the SWAP exit edge; in-flight is 0 here, so no result can be
  // mis-tagged by reloading the discard counter.
  assign flush_start = (state_q == StSwap) && clr_flag_q;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= StRun;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (CFG_COMMIT) state_d = StDrain;
      StDrain: if (inflight_q == '0) state_d = StSwap;
      StSwap:  state_d = clr_flag_q ? StZfill : StRun;
      StZfill: if (zcnt_q == ZW'(1)) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Outputs
  always_comb begin
    SRC_RDY = 1'b0;
    FIR_VIN = 1'b0;
    FIR_DIN = '0;
    if (!RST) begin
      unique case (state_q)
        StRun: begin
          SRC_RDY = 1'b1;
          FIR_VIN = SRC_VIN;
          FIR_DIN = SRC_DIN;
        end
        StZfill: FIR_VIN = 1'b1;
        default: ;
      endcase
    end
  end

  assign CFG_BUSY = (state_q != StRun);
  assign SNK_VOUT = !RST && FIR_VOUT && (discard_q == '0);
  assign ERR      = err_q;

  for (genvar k = 0; k < NTAPS; k++) begin : g_hbus
    assign H_BUS[k*WIDTH +: WIDTH] = active_q[k];
  end

  // Banks, counters and flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      inflight_q <= '0;
      discard_q  <= '0;
      zcnt_q     <= '0;
      err_q      <= 1'b0;
      clr_flag_q <= 1'b0;
    end else begin
      if (CFG_WE && !CFG_BUSY && (CFG_ADDR <= LastAddr)) shadow_q[CFG_ADDR] <= CFG_DATA;

      if ((state_q == StRun) && CFG_COMMIT) clr_flag_q <= CFG_CLR;

      // All taps move together so the FIR never sees a mixed bank.
      if (state_q == StSwap) begin
        for (int k = 0; k < NTAPS; k++) active_q[k] <= shadow_q[k];
      end

      if (flush_start)              zcnt_q <= FlushLen;
      else if (state_q == StZfill)  zcnt_q <= zcnt_q - ZW'(1);

      if (flush_start)                      discard_q <= FlushLen;
      else if (FIR_VOUT && discard_q != '0) discard_q <= discard_q - ZW'(1);

      // Saturating count of samples inside the FIR pipeline.
      unique case ({FIR_VIN, FIR_VOUT})
        2'b10: begin
          if (inflight_q == CntMax) err_q <= 1'b1;
          else                      inflight_q <= inflight_q + CNT_W'(1);
        end
        2'b01: begin
          if (inflight_q == '0) err_q <= 1'b1;
          else                  inflight_q <= inflight_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
module tb_fir_coef_ctrl;
  localparam int NTAPS = 11;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int HW    = NTAPS * WIDTH;

  logic             CLK, RST;
  logic             CFG_WE, CFG_COMMIT, CFG_CLR, CFG_BUSY;
  logic [3:0]       CFG_ADDR;
  logic [WIDTH-1:0] CFG_DATA, SRC_DIN, FIR_DIN;
  logic             SRC_VIN, SRC_RDY, FIR_VIN, FIR_VOUT, SNK_VOUT, ERR;
  logic [HW-1:0]    H_BUS;

  fir_coef_ctrl #(.NTAPS(NTAPS), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .CFG_COMMIT(CFG_COMMIT), .CFG_CLR(CFG_CLR), .CFG_BUSY(CFG_BUSY), .SRC_VIN(SRC_VIN),
    .SRC_DIN(SRC_DIN), .SRC_RDY(SRC_RDY), .FIR_VIN(FIR_VIN), .FIR_DIN(FIR_DIN),
    .FIR_VOUT(FIR_VOUT), .H_BUS(H_BUS), .SNK_VOUT(SNK_VOUT), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Downstream FIR stand-in: result valid 3 cycles after each accepted sample.
  logic [2:0] pipe;
  logic       vout_force;
  always_ff @(posedge CLK) begin
    if (RST) pipe <= '0;
    else     pipe <= {pipe[1:0], FIR_VIN};
  end
  assign FIR_VOUT = pipe[2] | vout_force;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    SRC_VIN = 0; CFG_WE = 0; CFG_COMMIT = 0; CFG_CLR = 0;
    repeat (n) next();
  endtask

  function automatic logic [WIDTH-1:0] tap(input logic [HW-1:0] bus, input int k);
    return bus[k*WIDTH +: WIDTH];
  endfunction

  typedef struct {
    logic             rst;
    logic             vin;
    logic [WIDTH-1:0] din;
    logic             exp_rdy;
    logic             exp_vin;
    logic [WIDTH-1:0] exp_din;
  } vec_t;

  vec_t vecs[8];

  // Reference model state for the random phase
  logic [WIDTH-1:0] shadow_m [NTAPS];
  logic [WIDTH-1:0] active_m [NTAPS];
  logic [WIDTH-1:0] pend_m   [NTAPS];
  bit               tagq[$];

  initial begin
    logic [HW-1:0] exp_bus;
    int busy_cnt, vcnt, bad_vin, first_rdy, flush_cnt, flush_bad, snk_cnt, vout_cnt;
    int cyc, run_from, act_cyc, zf_lo, zf_hi, last_vin, d, s;
    bit zf_on, run, zf, e_vin, e_snk;
    logic [WIDTH-1:0] e_din;

    RST = 1; SRC_VIN = 0; SRC_DIN = 0; CFG_WE = 0; CFG_ADDR = 0; CFG_DATA = 0;
    CFG_COMMIT = 0; CFG_CLR = 0; vout_force = 0;

    // ---------------- table: reset and pass-through ----------------
    vecs[0] = '{1'b1, 1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF};
    vecs[5] = '{1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 16'h8000};
    vecs[6] = '{1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16'h7FFF};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      RST = vecs[i].rst; SRC_VIN = vecs[i].vin; SRC_DIN = vecs[i].din;
      @(negedge CLK);
      chk($sformatf("vec%0d_rdy", i), HW'(SRC_RDY), HW'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_vin", i), HW'(FIR_VIN), HW'(vecs[i].exp_vin));
      chk($sformatf("vec%0d_din", i), HW'(FIR_DIN), HW'(vecs[i].exp_din));
      chk($sformatf("vec%0d_busy", i), HW'(CFG_BUSY), '0);
      if (vecs[i].rst) begin
        chk($sformatf("vec%0d_hbus", i), H_BUS, '0);
        chk($sformatf("vec%0d_err", i), HW'(ERR), '0);
        chk($sformatf("vec%0d_snk", i), HW'(SNK_VOUT), '0);
      end
      next();
    end
    idle(6);

    // ---------------- write all taps, commit without clear ----------------
    for (int k = 0; k < NTAPS; k++) begin
      CFG_WE = 1; CFG_ADDR = 4'(k); CFG_DATA = 16'(k + 1);
      next();
    end
    CFG_ADDR = 4'd11; CFG_DATA = 16'hDEAD;
    next();
    CFG_WE = 0; CFG_COMMIT = 1; CFG_CLR = 0;
    @(negedge CLK);
    chk("commit_cycle_rdy", HW'(SRC_RDY), HW'(1));
    next();
    CFG_COMMIT = 0;
    exp_bus = '0;
    for (int k = 0; k < NTAPS; k++) exp_bus[k*WIDTH +: WIDTH] = 16'(k + 1);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        CFG_WE = 1; CFG_ADDR = 0; CFG_DATA = 16'hAAAA; CFG_COMMIT = 1;
      end else begin
        CFG_WE = 0; CFG_COMMIT = 0;
      end
      @(negedge CLK);
      if (CFG_BUSY) busy_cnt++;
      if (i == 1) chk("hbus_before_swap", H_BUS, '0);
      if (i == 2) chk("hbus_after_swap", H_BUS, exp_bus);
      next();
    end
    chk("busy_cycles_noclr", HW'(busy_cnt), HW'(2));
    chk("tap3_value", HW'(tap(H_BUS, 3)), HW'(16'h0004));
    // Recommit with no writes: bank must be unaffected by the write issued during DRAIN.
    CFG_COMMIT = 1;
    next();
    idle(4);
    chk("hbus_after_recommit", H_BUS, exp_bus);

    // ---------------- drain wait ----------------
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      SRC_VIN = 1; SRC_DIN = 16'(100 + i);
      @(negedge CLK);
      if (FIR_VOUT) vcnt++;
      next();
    end
    SRC_VIN = 0; CFG_COMMIT = 1;
    @(negedge CLK);
    if (FIR_VOUT) vcnt++;
    next();
    CFG_COMMIT = 0; SRC_VIN = 1; SRC_DIN = 16'h0BAD;
    bad_vin = 0; first_rdy = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (first_rdy < 0 && FIR_VOUT) vcnt++;
      if (!SRC_RDY && FIR_VIN) bad_vin++;
      if (SRC_RDY && first_rdy < 0) begin
        first_rdy = i;
        chk("drain_vouts_before_rdy", HW'(vcnt), HW'(4));
      end
      next();
    end
    chk("drain_first_rdy", HW'(first_rdy), HW'(4));
    chk("drain_no_fir_vin", HW'(bad_vin), '0);
    idle(8);

    // ---------------- commit with clear, same-cycle write ----------------
    CFG_WE = 1; CFG_ADDR = 0; CFG_DATA = 16'h7FFF; CFG_COMMIT = 1; CFG_CLR = 1;
    next();
    CFG_WE = 0; CFG_COMMIT = 0; CFG_CLR = 0;
    busy_cnt = 0; flush_cnt = 0; flush_bad = 0; snk_cnt = 0; vout_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      SRC_VIN = (i == 12); SRC_DIN = 16'h0042;
      @(negedge CLK);
      if (CFG_BUSY) busy_cnt++;
      if (CFG_BUSY && FIR_VIN && FIR_DIN == '0) flush_cnt++;
      if (CFG_BUSY && (SRC_RDY || (FIR_VIN && FIR_DIN != '0))) flush_bad++;
      if (FIR_VOUT) vout_cnt++;
      if (SNK_VOUT) snk_cnt++;
      if (i == 15) chk("clr_real_snk", HW'(SNK_VOUT), HW'(1));
      next();
    end
    chk("clr_busy_cycles", HW'(busy_cnt), HW'(12));
    chk("clr_flush_pulses", HW'(flush_cnt), HW'(10));
    chk("clr_flush_clean", HW'(flush_bad), '0);
    chk("clr_vout_total", HW'(vout_cnt), HW'(11));
    chk("clr_snk_total", HW'(snk_cnt), HW'(1));
    chk("tap0_same_cycle_write", HW'(tap(H_BUS, 0)), HW'(16'h7FFF));

    // ---------------- in-flight underflow ----------------
    idle(4);
    chk("err_before", HW'(ERR), '0);
    vout_force = 1;
    next();
    vout_force = 0;
    @(negedge CLK);
    chk("err_set", HW'(ERR), HW'(1));
    next();
    CFG_COMMIT = 1;
    next();
    CFG_COMMIT = 0;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (CFG_BUSY) busy_cnt++;
      next();
    end
    chk("err_count_stays_zero", HW'(busy_cnt), HW'(2));
    chk("err_sticky", HW'(ERR), HW'(1));
    RST = 1;
    next();
    RST = 0;
    @(negedge CLK);
    chk("err_cleared_by_rst", HW'(ERR), '0);
    chk("hbus_cleared_by_rst", H_BUS, '0);
    next();

    // ---------------- randomized run vs. timeline model ----------------
    RST = 1;
    idle(2);
    RST = 0;
    for (int k = 0; k < NTAPS; k++) begin
      shadow_m[k] = '0; active_m[k] = '0; pend_m[k] = '0;
    end
    tagq.delete();
    cyc = 0; run_from = 0; act_cyc = -1; zf_on = 0; zf_lo = 0; zf_hi = -1; last_vin = -100;
    for (int n = 0; n < 2000; n++) begin
      if (cyc == act_cyc) for (int k = 0; k < NTAPS; k++) active_m[k] = pend_m[k];
      run = (cyc >= run_from);
      zf  = zf_on && (cyc >= zf_lo) && (cyc <= zf_hi);
      SRC_VIN    = ($urandom_range(0, 9) < 6);
      SRC_DIN    = 16'($urandom);
      CFG_WE     = ($urandom_range(0, 9) < 3);
      CFG_ADDR   = 4'($urandom_range(0, 15));
      CFG_DATA   = 16'($urandom);
      CFG_COMMIT = ($urandom_range(0, 99) < 4);
      CFG_CLR    = 1'($urandom_range(0, 1));
      e_vin = run ? SRC_VIN : zf;
      e_din = run ? SRC_DIN : '0;
      exp_bus = '0;
      for (int k = 0; k < NTAPS; k++) exp_bus[k*WIDTH +: WIDTH] = active_m[k];
      @(negedge CLK);
      e_snk = FIR_VOUT && (tagq.size() > 0) && tagq[0];
      chk("rnd_rdy", HW'(SRC_RDY), HW'(run));
      chk("rnd_busy", HW'(CFG_BUSY), HW'(!run));
      chk("rnd_vin", HW'(FIR_VIN), HW'(e_vin));
      chk("rnd_din", HW'(FIR_DIN), HW'(e_din));
      chk("rnd_hbus", H_BUS, exp_bus);
      chk("rnd_snk", HW'(SNK_VOUT), HW'(e_snk));
      chk("rnd_err", HW'(ERR), '0);
      if (FIR_VOUT && tagq.size() > 0) void'(tagq.pop_front());
      if (e_vin) begin
        tagq.push_back(run);
        last_vin = cyc;
      end
      if (run && CFG_WE && CFG_ADDR < 4'(NTAPS)) shadow_m[CFG_ADDR] = CFG_DATA;
      if (run && CFG_COMMIT) begin
        // Last drain cycle is when the final in-flight result has been retired.
        d = (cyc + 1 > last_vin + 4) ? cyc + 1 : last_vin + 4;
        s = d + 1;
        act_cyc = s + 1;
        for (int k = 0; k < NTAPS; k++) pend_m[k] = shadow_m[k];
        zf_on = CFG_CLR;
        zf_lo = s + 1;
        zf_hi = s + NTAPS - 1;
        run_from = CFG_CLR ? s + NTAPS : s + 1;
      end
      next();
      cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
